// File: rtl/mips_bus_pkg.sv
// rtl/mips_bus_pkg.sv - shared types and lane helpers for the CPU bus initiator
package mips_bus_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUS  = 2'b01,
      RESP = 2'b10
   } state_t;

   // bit0 of the mask is the byte at the word address (little-endian)
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SZ_BYTE: lane_mask = 4'b0001 << addr_lo;
         SZ_HALF: lane_mask = 4'b0011 << {addr_lo[1], 1'b0};
         SZ_WORD: lane_mask = 4'b1111;
         default: lane_mask = 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
      case (size)
         SZ_BYTE: replicate = {4{data[7:0]}};
         SZ_HALF: replicate = {2{data[15:0]}};
         default: replicate = data;
      endcase
   endfunction

endpackage

// File: rtl/mips_load_align.sv
// rtl/mips_load_align.sv - selects the addressed lane of a read word and extends it
module mips_load_align
   import mips_bus_pkg::*;
(
   input  logic [31:0] readdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   output logic [31:0] load_data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = readdata[{addr_lo, 3'b000} +: 8];
      half_lane = addr_lo[1] ? readdata[31:16] : readdata[15:0];
      case (size)
         SZ_BYTE: load_data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
         SZ_HALF: load_data = {{16{sign_ext & half_lane[15]}}, half_lane};
         default: load_data = readdata;
      endcase
   end

endmodule

// File: rtl/mips_bus_initiator.sv
// rtl/mips_bus_initiator.sv - single-outstanding load/store bus initiator with stall watchdog
module mips_bus_initiator
   import mips_bus_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 255
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   input  logic        waitrequest,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   input  logic [31:0] readdata
);

   localparam int WCW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

   state_t           state_q, state_d;
   logic             write_q;
   logic [1:0]       size_q;
   logic             sign_q;
   logic [1:0]       addr_lo_q;
   logic [WCW-1:0]   wait_cnt;
   logic             illegal;
   logic             bus_done;
   logic             timeout;
   logic [31:0]      load_data;

   always_comb begin
      case (req_size)
         SZ_BYTE: illegal = 1'b0;
         SZ_HALF: illegal = req_addr[0];
         SZ_WORD: illegal = (req_addr[1:0] != 2'b00);
         default: illegal = 1'b1;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
      resp_valid = 1'b0;
      bus_done   = 1'b0;
      timeout    = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = illegal ? RESP : BUS;
         end
         BUS: begin
            read  = ~write_q;
            write = write_q;
            if (!waitrequest) begin
               bus_done = 1'b1;
               state_d  = RESP;
            end else if (MAX_WAIT != 0 && 32'(wait_cnt) + 32'd1 == MAX_WAIT) begin
               // this stall cycle would make the count reach the limit
               timeout = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   mips_load_align u_load_align (
      .readdata  (readdata),
      .addr_lo   (addr_lo_q),
      .size      (size_q),
      .sign_ext  (sign_q),
      .load_data (load_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         address    <= '0;
         byteenable <= '0;
         writedata  <= '0;
         write_q    <= 1'b0;
         size_q     <= 2'b00;
         sign_q     <= 1'b0;
         addr_lo_q  <= 2'b00;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         wait_cnt   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && req_valid) begin
            resp_rdata <= '0;
            resp_err   <= illegal;
            if (!illegal) begin
               address    <= {req_addr[31:2], 2'b00};
               byteenable <= lane_mask(req_size, req_addr[1:0]);
               writedata  <= req_write ? replicate(req_size, req_wdata) : '0;
               write_q    <= req_write;
               size_q     <= req_size;
               sign_q     <= req_signed;
               addr_lo_q  <= req_addr[1:0];
            end
         end
         if (bus_done && !write_q) resp_rdata <= load_data;
         if (timeout) resp_err <= 1'b1;
         wait_cnt <= (state_q == BUS && state_d == BUS) ? wait_cnt + 1'b1 : '0;
      end
   end

endmodule

// File: doc/mips_bus_initiator.md
Name: mips_bus_initiator

Overview:
Bus-initiator side of the CPU's memory interface (address/read/write/waitrequest/byteenable/readdata/writedata). It takes one load/store request at a time from the datapath and drives a single word-aligned bus transaction. It generates byte lanes and replicated write data, holds the transaction through waitrequest stalls, and returns extracted, sign- or zero-extended load data. It sits between the mips_cpu_bus datapath and the memory responder.

Parameters:
MAX_WAIT, 255, max consecutive waitrequest cycles before abort with error; 0 disables the watchdog.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  datapath request present
req_ready  out  1  high only in IDLE; accept = req_valid & req_ready
req_write  in  1  1=store, 0=load
req_size  in  2  mem_size_t: 00 byte, 01 half, 10 word; 11 is illegal
req_signed  in  1  sign-extend load result (LB/LH)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  qualified by resp_valid: misaligned, illegal size, or timeout
address  out  32  req_addr with [1:0] forced to 00
read  out  1  bus read strobe
write  out  1  bus write strobe
waitrequest  in  1  responder stall
byteenable  out  4  active lanes; bit0 = byte at address+0 (little-endian)
writedata  out  32  lane-replicated store data
readdata  in  32  valid in any cycle with read=1 and waitrequest=0

Behaviour:
- Reset (asynchronous, active-low): state IDLE. req_ready=1 after release. All of these are 0: read, write, address, byteenable, writedata, resp_*, wait counter.
- FSM states: IDLE, BUS, RESP.
- IDLE -> BUS on accept when the request is legal. Address, lanes and write data are registered on accept. read or write is driven from the next cycle.
- IDLE -> RESP on accept when the request is illegal: half with addr[0]=1, word with addr[1:0]!=0, or size=11. These set resp_err=1 and issue no bus strobe.
- BUS: read or write is held high, and address, byteenable and writedata stay stable, while waitrequest=1.
  - On the first BUS cycle with waitrequest=0, sample readdata (for loads) and go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. Bus strobes are 0 in RESP.
- Latency with zero stalls: accept in cycle N, strobe in N+1, resp_valid in N+2. Each stall cycle adds 1.
- Back-to-back requests: the next accept can occur in the cycle after RESP, so the minimum spacing is 3 cycles.
- Byteenable:
  - byte: 0001 << addr[1:0]
  - half: 0011 << {addr[1],1'b0}
  - word: 1111
- Writedata:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load extraction: select the lane from addr[1:0]. For byte and half loads, sign-extend when req_signed=1, otherwise zero-extend. Word loads are passed through unchanged.
- Watchdog: the counter increments on each BUS cycle with waitrequest=1 and clears on leaving BUS.
  - If MAX_WAIT!=0 and the count reaches MAX_WAIT with waitrequest still 1, drop the strobe and go to RESP with resp_err=1.
- Reset mid-transaction: strobes drop immediately (asynchronous) and no resp_valid is produced. The datapath must reissue the request.
- req_* inputs are ignored outside IDLE. waitrequest is ignored outside BUS.

Decomposition:
- Package mips_bus_pkg holds:
  - typedef enum mem_size_t {SZ_BYTE, SZ_HALF, SZ_WORD}
  - typedef enum state_t {IDLE, BUS, RESP}
  - function lane_mask(size, addr_lo)
  - function replicate(size, data)
- One combinational sub-module, mips_load_align: inputs readdata, addr_lo, size, signed; output the 32-bit extended result.
- The FSM and watchdog stay in the top module.

Test Plan:
- Memory bytes 4..7 = FC,18,3A,5C; LW addr 4, waitrequest=0 -> address=4, byteenable=1111, read high 1 cycle, resp_rdata=0x5C3A18FC at N+2, resp_err=0.
- Same memory; LB signed at 4 -> 0xFFFFFFFC; LBU at 4 -> 0x000000FC; LB signed at 5 -> 0x00000018 with byteenable=0010; LH signed at 6 -> 0x00005C3A with byteenable=1100.
- SB wdata=0x000000AB at 9 -> address=8, byteenable=0010, writedata=0xABABABAB, write high 1 cycle; memory byte 9 becomes AB, bytes 8/10/11 unchanged; resp_rdata=0.
- SW at 8 with waitrequest high for 3 cycles -> write and all bus outputs stable for 4 cycles, resp_valid at N+5.
- LW at 6, and SH at 5 -> no read/write strobe; resp_valid at N+1 with resp_err=1; next request is accepted normally.
- MAX_WAIT=4 with waitrequest stuck high -> strobe drops after 4 stall cycles, resp_err=1. Separately, assert reset during a stall -> read=0 immediately, no resp_valid, req_ready=1 after release.
